// File: rtl/sb_config_pkg.sv
// Shared constants, sizing helpers and FSM encodings for the switchbox config loader.
// Optional checksum path is enabled by defining SB_CONFIG_CHECKSUM_EN.
package sb_config_pkg;

  localparam int CONFIG_WIDTH_DEF = 264;
  localparam int WORD_WIDTH_DEF   = 8;

  function automatic int num_words(input int cw, input int ww);
    return (cw + ww - 1) / ww;
  endfunction

  function automatic int cnt_width(input int nw);
    return $clog2(nw + 1);
  endfunction

  localparam int NUM_WORDS_DEF = num_words(CONFIG_WIDTH_DEF, WORD_WIDTH_DEF);
  localparam int CNT_W_DEF     = cnt_width(NUM_WORDS_DEF);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/sb_config_if.sv
// Configuration word stream from the bitstream distributor (master) to the loader (slave).
// Transfer on word_valid && word_ready; word_valid is ignored while word_ready is low.
interface sb_config_if #(
  parameter int WORD_WIDTH = sb_config_pkg::WORD_WIDTH_DEF
);
  logic [WORD_WIDTH-1:0] word_in;
  logic                  word_valid;
  logic                  word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/sb_config_checksum.sv
// XOR accumulator over accepted data words; match compares the running XOR with din.
// Single-cycle update, combinational compare; no backpressure of its own.
module sb_config_checksum
  import sb_config_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] din,
  output logic                  match
);

  logic [WORD_WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q ^ din;
    end
  end

  assign match = (acc_q == din);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/sb_config_loader.sv
// Streams a switchbox image into a shadow register and commits it atomically one edge after the last word.
// Optional XOR checksum word when SB_CONFIG_CHECKSUM_EN is defined; word_ready is high only while loading.
module sb_config_loader
  import sb_config_pkg::*;
#(
  parameter int CONFIG_WIDTH = CONFIG_WIDTH_DEF,
  parameter int WORD_WIDTH   = WORD_WIDTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  sb_config_if.slave              wr,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_valid,
  output logic                    busy,
  output logic                    error
);

  localparam int NUM_WORDS = num_words(CONFIG_WIDTH, WORD_WIDTH);
  localparam int CNT_W     = cnt_width(NUM_WORDS);
  localparam int SHADOW_W  = NUM_WORDS * WORD_WIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  logic [2:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SHADOW_W-1:0]     shadow_q, shadow_d;
  logic [CONFIG_WIDTH-1:0] cfg_q, cfg_d;
  logic                    cfg_vld_q, cfg_vld_d;
  logic                    word_rdy;
  logic                    xfer;

  assign word_rdy        = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign xfer            = wr.word_valid && word_rdy;
  assign wr.word_ready   = word_rdy;
  assign busy            = word_rdy || (state_q == ST_COMMIT);
  assign config_out      = cfg_q;
  assign config_valid    = cfg_vld_q;

`ifdef SB_CONFIG_CHECKSUM_EN
  logic err_q, err_d;
  logic acc_clr, acc_en, chk_match;

  sb_config_checksum #(.WORD_WIDTH(WORD_WIDTH)) u_checksum (
    .clock (clock),
    .reset (reset),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (wr.word_in),
    .match (chk_match)
  );

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    cfg_d     = cfg_q;
    cfg_vld_d = cfg_vld_q;
`ifdef SB_CONFIG_CHECKSUM_EN
    err_d   = err_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Previous image stays live on config_out until the next commit.
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
`ifdef SB_CONFIG_CHECKSUM_EN
          err_d   = 1'b0;
          acc_clr = 1'b1;
`endif
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          shadow_d[int'(cnt_q) * WORD_WIDTH +: WORD_WIDTH] = wr.word_in;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef SB_CONFIG_CHECKSUM_EN
          acc_en = 1'b1;
          if (cnt_q == LAST_IDX) state_d = ST_CHECK;
`else
          if (cnt_q == LAST_IDX) state_d = ST_COMMIT;
`endif
        end
      end
`ifdef SB_CONFIG_CHECKSUM_EN
      ST_CHECK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          if (chk_match) begin
            state_d = ST_COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`endif
      ST_COMMIT: begin
        cfg_d     = shadow_q[CONFIG_WIDTH-1:0];
        cfg_vld_d = 1'b1;
        state_d   = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      cfg_q     <= '0;
      cfg_vld_q <= 1'b0;
`ifdef SB_CONFIG_CHECKSUM_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      cfg_q     <= cfg_d;
      cfg_vld_q <= cfg_vld_d;
`ifdef SB_CONFIG_CHECKSUM_EN
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_sb_config_loader.sv
// Scoreboard bench for sb_config_loader: each load pushes its expected outcome, a monitor checks it when busy falls.
module tb_sb_config_loader;
  import sb_config_pkg::*;

  localparam int CW = CONFIG_WIDTH_DEF;
  localparam int WW = WORD_WIDTH_DEF;
  localparam int NW = NUM_WORDS_DEF;
`ifdef SB_CONFIG_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int XF = NW + (CHK ? 1 : 0);

  logic          clock = 1'b0;
  logic          reset, start, abort;
  logic [CW-1:0] config_out;
  logic          config_valid, busy, error;

  sb_config_if #(.WORD_WIDTH(WW)) wif();

  sb_config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .wr           (wif),
    .config_out   (config_out),
    .config_valid (config_valid),
    .busy         (busy),
    .error        (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            id;
    logic [CW-1:0] cfg;
    logic          vld;
    logic          err;
    int            xfers;
    int            nrdy;
    bit            commit;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [WW-1:0] word_of(input int pat, input int k);
    logic [WW-1:0] r;
    case (pat)
      0:       r = WW'(k + 1);
      1:       r = WW'(8'hA5 ^ WW'(k * 7));
      default: r = WW'(8'hFF - k);
    endcase
    return r;
  endfunction

  function automatic logic [CW-1:0] image_of(input int pat);
    logic [CW-1:0] img = '0;
    for (int k = 0; k < NW; k++) img[k*WW +: WW] = word_of(pat, k);
    return img;
  endfunction

  function automatic logic [WW-1:0] xor_of(input int pat);
    logic [WW-1:0] x = '0;
    for (int k = 0; k < NW; k++) x ^= word_of(pat, k);
    return x;
  endfunction

  task automatic push_exp(input int id, input logic [CW-1:0] cfg, input logic vld, input logic err,
                          input int xfers, input int nrdy, input bit commit);
    exp_t e;
    e.id = id; e.cfg = cfg; e.vld = vld; e.err = err;
    e.xfers = xfers; e.nrdy = nrdy; e.commit = commit;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // kill_kind: 0 none, 1 abort when k==kill_at, 2 reset when k==kill_at
  task automatic run_load(input int pat, input bit stall, input int kill_at, input int kill_kind,
                          input bit bad_chk, input bit glitch);
    int k = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (k < NW) begin
      if (kill_kind == 1 && k == kill_at) begin
        abort = 1'b1; wif.word_valid = 1'b1; wif.word_in = 8'hEE;
        tick();
        abort = 1'b0; wif.word_valid = 1'b0;
        tick(); tick();
        return;
      end
      if (kill_kind == 2 && k == kill_at) begin
        reset = 1'b1; wif.word_valid = 1'b0;
        tick();
        @(negedge clock);
        check("rst_mid.config_out", config_out, '0);
        check("rst_mid.config_valid", CW'(config_valid), '0);
        check("rst_mid.busy", CW'(busy), '0);
        check("rst_mid.word_ready", CW'(wif.word_ready), '0);
        reset = 1'b0;
        tick();
        return;
      end
      wif.word_in    = word_of(pat, k);
      wif.word_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      start          = glitch && (k == 5);
      tick();
      start = 1'b0;
      if (wif.word_valid) k++;
    end
    if (CHK) begin
      wif.word_in    = bad_chk ? (xor_of(pat) ^ 8'h01) : xor_of(pat);
      wif.word_valid = 1'b1;
      tick();
    end
    wif.word_valid = 1'b0;
    start = glitch;
    tick();
    start = 1'b0;
    tick();
  endtask

  // Monitor: counts transfers per load and checks the scoreboard entry when busy falls.
  int   ncyc = 0, xf = 0, nr = 0, last_xf = 0;
  logic prev_busy = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    ncyc++;
    if (busy && !prev_busy) begin
      xf = 0;
      nr = 0;
    end
    if (busy && !wif.word_ready) nr++;
    if (wif.word_valid && wif.word_ready && !abort && !reset) begin
      xf++;
      last_xf = ncyc;
    end
    if (prev_busy && !busy) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", CW'(1), '0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("load%0d.config_out", e.id), config_out, e.cfg);
        check($sformatf("load%0d.config_valid", e.id), CW'(config_valid), CW'(e.vld));
        check($sformatf("load%0d.error", e.id), CW'(error), CW'(e.err));
        check($sformatf("load%0d.transfers", e.id), CW'(xf), CW'(e.xfers));
        check($sformatf("load%0d.notready_cycles", e.id), CW'(nr), CW'(e.nrdy));
        if (e.commit) check($sformatf("load%0d.commit_latency", e.id), CW'(ncyc - last_xf), CW'(2));
      end
    end
    prev_busy = busy;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    wif.word_valid = 1'b0; wif.word_in = '0;
    tick(); tick();
    @(negedge clock);
    check("reset.config_out", config_out, '0);
    check("reset.config_valid", CW'(config_valid), '0);
    check("reset.busy", CW'(busy), '0);
    check("reset.word_ready", CW'(wif.word_ready), '0);
    check("reset.error", CW'(error), '0);
    reset = 1'b0;
    tick();

    // word_valid held high in IDLE must not start anything
    wif.word_valid = 1'b1; wif.word_in = 8'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clock);
      check("idle.word_ready", CW'(wif.word_ready), '0);
      check("idle.busy", CW'(busy), '0);
    end
    wif.word_valid = 1'b0;
    tick();

    push_exp(1, image_of(0), 1'b1, 1'b0, XF, 1, 1'b1);
    run_load(0, 1'b0, 0, 0, 1'b0, 1'b0);
    check("basic.byte0", CW'(config_out[7:0]), CW'(8'h01));
    check("basic.byte32", CW'(config_out[263:256]), CW'(8'h21));

    push_exp(2, image_of(0), 1'b1, 1'b0, XF, 1, 1'b1);
    run_load(0, 1'b1, 0, 0, 1'b0, 1'b0);

    push_exp(3, image_of(1), 1'b1, 1'b0, XF, 1, 1'b1);
    run_load(1, 1'b0, 0, 0, 1'b0, 1'b0);
    push_exp(4, image_of(1), 1'b1, 1'b0, 10, 0, 1'b0);
    run_load(2, 1'b0, 10, 1, 1'b0, 1'b0);
    @(negedge clock);
    check("abort.busy", CW'(busy), '0);
    check("abort.word_ready", CW'(wif.word_ready), '0);
    push_exp(5, image_of(2), 1'b1, 1'b0, XF, 1, 1'b1);
    run_load(2, 1'b0, 0, 0, 1'b0, 1'b0);

    // start pulsed during LOAD and COMMIT is ignored
    push_exp(6, image_of(1), 1'b1, 1'b0, XF, 1, 1'b1);
    run_load(1, 1'b0, 0, 0, 1'b0, 1'b1);
    @(negedge clock);
    check("glitch.no_restart", CW'(busy), '0);

    push_exp(7, '0, 1'b0, 1'b0, 20, 0, 1'b0);
    run_load(0, 1'b0, 20, 2, 1'b0, 1'b0);

`ifdef SB_CONFIG_CHECKSUM_EN
    push_exp(8, image_of(2), 1'b1, 1'b0, XF, 1, 1'b1);
    run_load(2, 1'b1, 0, 0, 1'b0, 1'b0);
    push_exp(9, image_of(2), 1'b1, 1'b1, XF, 0, 1'b0);
    run_load(1, 1'b0, 0, 0, 1'b1, 1'b0);
    @(negedge clock);
    check("chk_bad.error_sticky", CW'(error), CW'(1));
    push_exp(10, image_of(0), 1'b1, 1'b0, XF, 1, 1'b1);
    run_load(0, 1'b0, 0, 0, 1'b0, 1'b0);
`else
    push_exp(8, image_of(2), 1'b1, 1'b0, XF, 1, 1'b1);
    run_load(2, 1'b1, 0, 0, 1'b0, 1'b0);
`endif

    repeat (4) tick();
    check("sb_leftover", CW'(sb_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
